tmp_decimator: RTL and testbench
================================

# tmp_decimator

Decimation stage that sits directly downstream of the temperature-sensor phase controller. It consumes the controller's per-cycle comparator decision (`cmp` qualified by a one-cycle `sample` strobe) and counts ones over a fixed oversampling window (first-order incremental / sinc1). It presents the resulting temperature code to the readout logic through a valid/ready handshake. It also handles settling-sample discard, continuous conversion, abort, and result overrun.

## Interface
- `OSR_LOG2`, default 8: window length is 2^OSR_LOG2 accumulated samples.
- `SETTLE`, default 4: decisions discarded after each `start`, range 0..15.
- `CODE_W`, localparam = OSR_LOG2+1: width of the result code.

Ports:
- `clk` in 1: single clock; all logic on posedge.
- `reset_n` in 1: reset is asynchronous and active-low.
- `start` in 1: one-cycle pulse; begins a conversion from IDLE.
- `continuous` in 1: level, sampled at window end; 1 = restart accumulation immediately.
- `abort` in 1: synchronous; discards the partial conversion and returns to IDLE.
- `sample` in 1: one-cycle strobe; `cmp` is valid this cycle.
- `cmp` in 1: comparator decision.
- `out_code` out CODE_W: count of ones in the last completed window.
- `out_valid` out 1: `out_code` holds an untaken result.
- `out_ready` in 1: consumer accepts the result when `out_valid` && `out_ready`.
- `busy` out 1: state != IDLE.
- `overrun` out 1: sticky; a result was overwritten before it was taken.

## Operation
States: IDLE, SETTLE, ACCUM.

- **IDLE**
  - `start` -> SETTLE if SETTLE>0, else ACCUM.
  - On leaving IDLE: `acc`=0, `scnt`=0, `overrun`=0.
- **SETTLE**
  - Each `sample` increments `scnt`; `cmp` is ignored.
  - On the strobe where `scnt`==SETTLE-1 -> ACCUM.
- **ACCUM**
  - Each `sample`: `acc` += `cmp`, `scnt` += 1. `scnt` is OSR_LOG2 bits and wraps.
  - On the strobe completing sample 2^OSR_LOG2, the window ends:
    - `out_code` <= `acc`+`cmp` (range 0..2^OSR_LOG2, no saturation).
    - `out_valid` <= 1.
    - If `continuous`=1: stay in ACCUM with `acc`=0. No re-settling.
    - Else: go to IDLE.
- **`start`** while `busy` is ignored. Pulses on `start` that coincide with `abort` are also ignored.
- **`abort`** has priority over `sample` in the same cycle:
  - Next state IDLE; `acc` and `scnt` cleared.
  - `out_valid`, `out_code` and `overrun` are unchanged.
- **Output slot**
  - Handshake transfer clears `out_valid` unless a window ends in the same cycle.
  - Window end while `out_valid`=1 and `out_ready`=0: overwrite `out_code`, keep `out_valid`=1, set `overrun`=1.
  - Window end in the same cycle as a transfer: load the new code, `out_valid` stays 1, no overrun.
- `sample` outside SETTLE/ACCUM is ignored.

## Timing
- Reset (`reset_n`=0, asynchronous):
  - State IDLE.
  - `acc`=0, `scnt`=0.
  - `out_code`=0, `out_valid`=0, `busy`=0, `overrun`=0.
- `busy` rises 1 cycle after `start`.
- `out_valid` and `out_code` update on the clock edge that samples the final strobe. They are visible the cycle after that strobe.
- Latency: no combinational path from `cmp` or `sample` to any output.
- `out_code` is stable while `out_valid`=1 and `out_ready`=0, except on overwrite.
- `out_ready` may be held high permanently. The consumer then sees a 1-cycle `out_valid` pulse per window.
- Back-to-back strobes on consecutive cycles must be supported.

## Structure
- Shared package `tmp_pkg`:
  - State enum (`TD_IDLE`, `TD_SETTLE`, `TD_ACCUM`).
  - Default OSR_LOG2 and SETTLE constants, shared with the controller.
- One sub-module, `tmp_out_slot`: a CODE_W holding register with valid/ready, overwrite and sticky `overrun`.
- Top level: FSM plus counters only.

## Test plan
Bench uses OSR_LOG2=4 (16-sample window) and SETTLE=2.
1. Reset: drive `reset_n`=0 mid-simulation between edges -> all outputs 0 immediately; state IDLE.
2. `start`, 2 settle strobes with `cmp`=1, then 16 strobes with `cmp`=1 on exactly 6 -> `out_code`=6, `out_valid`=1 the cycle after the 16th; `busy`=0.
3. All-ones window -> `out_code`=16 (0x10); all-zeros window -> 0; strobes on every cycle and with gaps give identical codes.
4. `continuous`=1, `out_ready`=0, windows with 5 then 9 ones -> `out_code`=9, `overrun`=1. Rerun with `out_ready`=1 in the second window's end cycle -> `out_code`=9, `overrun`=0.
5. `abort` after 7 ACCUM strobes, `abort` coincident with `sample` -> IDLE, `busy`=0, no `out_valid`. Re-`start` with 3 ones -> `out_code`=3 (no residue).
6. `start` pulsed during ACCUM, and `sample` strobes in IDLE -> no effect on count or state.

Source files
------------

// File: rtl/tmp_pkg.sv
// Shared definitions for the temperature-sensor datapath: decimator state
// encoding and default oversampling/settling constants used by the controller too.
package tmp_pkg;

    typedef enum logic [1:0] {
        TD_IDLE   = 2'd0,
        TD_SETTLE = 2'd1,
        TD_ACCUM  = 2'd2
    } td_state_e;

    localparam int TMP_OSR_LOG2_DEF = 8;
    localparam int TMP_SETTLE_DEF   = 4;

endpackage

// File: rtl/tmp_out_slot.sv
// Single-entry result register with valid/ready, overwrite-on-new-result and a
// sticky overrun flag.
module tmp_out_slot #(
    parameter int CODE_W = 9
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic [CODE_W-1:0] load_code,
    input  logic              clr_overrun,
    input  logic              out_ready,
    output logic [CODE_W-1:0] out_code,
    output logic              out_valid,
    output logic              overrun
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_code  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (load) begin
                out_code  <= load_code;
                out_valid <= 1'b1;
                // A new result lands on an untaken one only if nobody takes it now
                if (out_valid && !out_ready)
                    overrun <= 1'b1;
            end else begin
                if (out_valid && out_ready)
                    out_valid <= 1'b0;
                if (clr_overrun)
                    overrun <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/tmp_decimator.sv
// Sinc1 decimator: counts comparator ones over a 2^OSR_LOG2 window after
// discarding SETTLE decisions, and hands the code to an output slot.
module tmp_decimator import tmp_pkg::*; #(
    parameter  int OSR_LOG2 = TMP_OSR_LOG2_DEF,
    parameter  int SETTLE   = TMP_SETTLE_DEF,
    localparam int CODE_W   = OSR_LOG2 + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              continuous,
    input  logic              abort,
    input  logic              sample,
    input  logic              cmp,
    output logic [CODE_W-1:0] out_code,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              overrun
);

    // scnt doubles as the settle counter, so it must also hold SETTLE-1 (up to 14)
    localparam int SCNT_W = (OSR_LOG2 > 4) ? OSR_LOG2 : 4;
    localparam logic [SCNT_W-1:0] WIN_LAST    = SCNT_W'((2 ** OSR_LOG2) - 1);
    localparam logic [SCNT_W-1:0] SETTLE_LAST = SCNT_W'((SETTLE > 0) ? SETTLE - 1 : 0);

    td_state_e         state, state_nxt;
    logic [CODE_W-1:0] acc, acc_nxt;
    logic [SCNT_W-1:0] scnt, scnt_nxt;
    logic              win_end;
    logic              clr_ovr;
    logic [CODE_W-1:0] cmp_ext;
    logic [CODE_W-1:0] win_code;

    assign cmp_ext  = {{(CODE_W-1){1'b0}}, cmp};
    assign win_code = acc + cmp_ext;
    assign busy     = (state != TD_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= TD_IDLE;
            acc   <= '0;
            scnt  <= '0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            scnt  <= scnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        scnt_nxt  = scnt;
        win_end   = 1'b0;
        clr_ovr   = 1'b0;
        unique case (state)
            TD_IDLE: begin
                if (start && !abort) begin
                    state_nxt = (SETTLE > 0) ? TD_SETTLE : TD_ACCUM;
                    acc_nxt   = '0;
                    scnt_nxt  = '0;
                    clr_ovr   = 1'b1;
                end
            end
            TD_SETTLE: begin
                if (abort) begin
                    state_nxt = TD_IDLE;
                    acc_nxt   = '0;
                    scnt_nxt  = '0;
                end else if (sample) begin
                    if (scnt == SETTLE_LAST) begin
                        state_nxt = TD_ACCUM;
                        scnt_nxt  = '0;
                    end else begin
                        scnt_nxt = scnt + SCNT_W'(1);
                    end
                end
            end
            TD_ACCUM: begin
                if (abort) begin
                    state_nxt = TD_IDLE;
                    acc_nxt   = '0;
                    scnt_nxt  = '0;
                end else if (sample) begin
                    if (scnt == WIN_LAST) begin
                        // Continuous mode rolls straight into the next window
                        win_end  = 1'b1;
                        acc_nxt  = '0;
                        scnt_nxt = '0;
                        if (!continuous)
                            state_nxt = TD_IDLE;
                    end else begin
                        acc_nxt  = acc + cmp_ext;
                        scnt_nxt = scnt + SCNT_W'(1);
                    end
                end
            end
            default: begin
                state_nxt = TD_IDLE;
                acc_nxt   = '0;
                scnt_nxt  = '0;
            end
        endcase
    end

    tmp_out_slot #(
        .CODE_W (CODE_W)
    ) u_slot (
        .clk         (clk),
        .reset_n     (reset_n),
        .load        (win_end),
        .load_code   (win_code),
        .clr_overrun (clr_ovr),
        .out_ready   (out_ready),
        .out_code    (out_code),
        .out_valid   (out_valid),
        .overrun     (overrun)
    );

endmodule

// File: tb/tb_tmp_decimator.sv
// Randomized bench for tmp_decimator: expected codes are popcounts of the
// generated comparator windows; handshake/overrun expectations follow the slot rules.
module tb_tmp_decimator;

    localparam int OSR = 4;
    localparam int SET = 2;
    localparam int CW  = OSR + 1;
    localparam int WIN = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          continuous = 1'b0;
    logic          abort = 1'b0;
    logic          sample = 1'b0;
    logic          cmp = 1'b0;
    logic          out_ready = 1'b0;
    logic [CW-1:0] out_code;
    logic          out_valid;
    logic          busy;
    logic          overrun;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tmp_decimator #(
        .OSR_LOG2 (OSR),
        .SETTLE   (SET)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .continuous (continuous),
        .abort      (abort),
        .sample     (sample),
        .cmp        (cmp),
        .out_code   (out_code),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .overrun    (overrun)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic c, input bit gaps);
        if (gaps) repeat ($urandom_range(0, 2)) cyc();
        sample = 1'b1;
        cmp    = c;
        cyc();
        sample = 1'b0;
        cmp    = 1'b0;
    endtask

    function automatic logic [WIN-1:0] pattern(input int ones);
        logic [WIN-1:0] p;
        logic t;
        int j;
        p = '0;
        for (int i = 0; i < ones; i++) p[i] = 1'b1;
        for (int i = WIN - 1; i > 0; i--) begin
            j = int'($urandom_range(0, i));
            t = p[i]; p[i] = p[j]; p[j] = t;
        end
        return p;
    endfunction

    function automatic int popcnt(input logic [WIN-1:0] p);
        int n = 0;
        for (int i = 0; i < WIN; i++) n += int'(p[i]);
        return n;
    endfunction

    task automatic window(input logic [WIN-1:0] p, input bit gaps);
        for (int i = 0; i < WIN; i++) strobe(p[i], gaps);
    endtask

    task automatic begin_conv(input bit gaps);
        start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (SET) strobe(1'b1, gaps);
    endtask

    task automatic take();
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
    endtask

    initial begin
        logic [WIN-1:0] p, q;
        bit r, vld, ovr;

        // reset state
        #12;
        chk("rst_code", out_code, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovr", overrun, 0);
        reset_n = 1'b1;
        cyc();

        // basic window with exactly six ones
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("busy_rise", busy, 1);
        repeat (SET) strobe(1'b1, 1'b0);
        p = pattern(6);
        window(p, 1'b0);
        chk("w6_valid", out_valid, 1);
        chk("w6_code", out_code, 6);
        chk("w6_busy", busy, 0);
        cyc();
        chk("w6_hold", out_code, 6);
        take();
        chk("w6_taken", out_valid, 0);

        // all ones, all zeros, and one random pattern with and without gaps
        begin_conv(1'b0);
        window('1, 1'b0);
        chk("all1_code", out_code, 16);
        take();
        begin_conv(1'b1);
        window('0, 1'b1);
        chk("all0_code", out_code, 0);
        chk("all0_valid", out_valid, 1);
        take();
        q = WIN'($urandom);
        for (int g = 0; g < 2; g++) begin
            begin_conv(g[0]);
            window(q, g[0]);
            chk(g[0] ? "rnd_gap_code" : "rnd_b2b_code", out_code, popcnt(q));
            take();
        end

        // continuous with overrun, then asynchronous reset mid-conversion
        continuous = 1'b1;
        begin_conv(1'b0);
        window(pattern(5), 1'b1);
        chk("c5_code", out_code, 5);
        chk("c5_ovr", overrun, 0);
        chk("c5_busy", busy, 1);
        window(pattern(9), 1'b0);
        chk("c9_code", out_code, 9);
        chk("c9_ovr", overrun, 1);
        chk("c9_busy", busy, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_code", out_code, 0);
        chk("arst_valid", out_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_ovr", overrun, 0);
        cyc();
        reset_n = 1'b1;
        cyc();

        // rerun with the consumer taking in the second window's end cycle
        begin_conv(1'b0);
        window(pattern(5), 1'b0);
        chk("r5_code", out_code, 5);
        p = pattern(9);
        for (int i = 0; i < WIN - 1; i++) strobe(p[i], 1'b1);
        out_ready  = 1'b1;
        continuous = 1'b0;
        strobe(p[WIN-1], 1'b0);
        out_ready = 1'b0;
        chk("r9_code", out_code, 9);
        chk("r9_valid", out_valid, 1);
        chk("r9_ovr", overrun, 0);
        chk("r9_busy", busy, 0);
        take();

        // random continuous windows with random take-on-end
        continuous = 1'b1;
        begin_conv(1'b1);
        vld = 1'b0;
        ovr = 1'b0;
        for (int k = 0; k < 4; k++) begin
            p = WIN'($urandom);
            r = bit'($urandom_range(0, 1));
            for (int i = 0; i < WIN - 1; i++) strobe(p[i], 1'b1);
            out_ready = r;
            strobe(p[WIN-1], 1'b0);
            out_ready = 1'b0;
            if (vld && !r) ovr = 1'b1;
            vld = 1'b1;
            chk("cr_code", out_code, popcnt(p));
            chk("cr_ovr", overrun, ovr);
        end
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        continuous = 1'b0;
        chk("cr_abort_busy", busy, 0);
        chk("cr_abort_ovr", overrun, ovr);
        chk("cr_abort_valid", out_valid, 1);
        take();

        // abort after 7 accumulate strobes, and abort coincident with a strobe
        begin_conv(1'b0);
        repeat (7) strobe(1'b1, 1'b0);
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        chk("ab7_busy", busy, 0);
        chk("ab7_valid", out_valid, 0);
        begin_conv(1'b0);
        repeat (7) strobe(1'b1, 1'b0);
        abort = 1'b1;
        strobe(1'b1, 1'b0);
        abort = 1'b0;
        chk("abs_busy", busy, 0);
        chk("abs_valid", out_valid, 0);
        start = 1'b1;
        abort = 1'b1;
        cyc();
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_busy", busy, 0);
        begin_conv(1'b0);
        window(pattern(3), 1'b1);
        chk("ab_rerun_code", out_code, 3);
        take();

        // strobes in IDLE ignored; start pulse during accumulation ignored
        repeat (5) strobe(1'b1, 1'b0);
        chk("idle_busy", busy, 0);
        chk("idle_valid", out_valid, 0);
        p = WIN'($urandom);
        begin_conv(1'b1);
        for (int i = 0; i < WIN; i++) begin
            if (i == 5) begin
                start = 1'b1;
                cyc();
                start = 1'b0;
            end
            strobe(p[i], 1'b1);
        end
        chk("restart_code", out_code, popcnt(p));
        chk("restart_busy", busy, 0);
        take();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
